// File: rtl/key_if.sv
// Keypad signal bundle between the raw key lines and the conditioned key outputs.
// The master modport belongs to the side that drives key_raw; the conditioner uses slave.
interface key_if #(
    parameter int NUM_KEYS = 12
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_hold;
    logic                any_pressed;

    modport master (
        output key_raw,
        input  key_level, key_press, key_release, key_hold, any_pressed
    );

    modport slave (
        input  key_raw,
        output key_level, key_press, key_release, key_hold, any_pressed
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debounce FSM, press/release edge pulses and long-hold detection.
// Every key runs its own independent FSM and counters; nothing is shared between keys.
module key_conditioner #(
    parameter int NUM_KEYS        = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    key_if.slave keys
);
    localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] HOLD_MAX = 26'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } key_state_e;

    logic [NUM_KEYS-1:0] meta;
    logic [NUM_KEYS-1:0] sync;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;
    logic [NUM_KEYS-1:0] hold;

    // NOTE: non-blocking assignments make sync take last cycle's meta, so these really are two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= keys.key_raw;
            sync <= meta;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_e  state;
        logic [19:0] db_cnt;
        logic [25:0] hold_cnt;
        logic        level_r;
        logic        press_r;
        logic        rel_r;
        logic        hold_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= STABLE_LO;
                db_cnt   <= '0;
                hold_cnt <= '0;
                level_r  <= 1'b0;
                press_r  <= 1'b0;
                rel_r    <= 1'b0;
                hold_r   <= 1'b0;
            end else begin
                press_r <= 1'b0;
                rel_r   <= 1'b0;

                // Hold time accrues through PEND_LO too, so a release-side bounce keeps it.
                if (level_r && (hold_cnt != HOLD_MAX)) begin
                    hold_cnt <= hold_cnt + 26'd1;
                    if (hold_cnt + 26'd1 == HOLD_MAX) begin
                        hold_r <= 1'b1;
                    end
                end

                case (state)
                    STABLE_LO: begin
                        hold_cnt <= '0;
                        if (sync[k]) begin
                            state  <= PEND_HI;
                            db_cnt <= '0;
                        end
                    end
                    PEND_HI: begin
                        if (!sync[k]) begin
                            state  <= STABLE_LO;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state   <= STABLE_HI;
                            db_cnt  <= '0;
                            level_r <= 1'b1;
                            press_r <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + 20'd1;
                        end
                    end
                    STABLE_HI: begin
                        if (!sync[k]) begin
                            state  <= PEND_LO;
                            db_cnt <= '0;
                        end
                    end
                    PEND_LO: begin
                        if (sync[k]) begin
                            state  <= STABLE_HI;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            // Falling edge overrides the hold update above in the same cycle.
                            state    <= STABLE_LO;
                            db_cnt   <= '0;
                            level_r  <= 1'b0;
                            rel_r    <= 1'b1;
                            hold_r   <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 20'd1;
                        end
                    end
                    default: begin
                        state  <= STABLE_LO;
                        db_cnt <= '0;
                    end
                endcase
            end
        end

        assign level[k] = level_r;
        assign press[k] = press_r;
        assign rel[k]   = rel_r;
        assign hold[k]  = hold_r;
    end

    assign keys.key_level   = level;
    assign keys.key_press   = press;
    assign keys.key_release = rel;
    assign keys.key_hold    = hold;
    assign keys.any_pressed = |level;
endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Directed scenarios plus randomized key activity against a run-length reference model.
module tb_key_conditioner;
    localparam int NK = 12;
    localparam int D  = 4;
    localparam int H  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    key_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keys(kif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a key flips once its synchronized input has disagreed with the
    // accepted level for D+1 consecutive samples; hold is "H or more cycles since the rise".
    logic [NK-1:0] m_level, m_press, m_release, m_hold, d1, d2;
    int            m_run[NK];
    int            m_rise[NK];
    int            cyc;

    task automatic model_reset();
        m_level = '0; m_press = '0; m_release = '0; m_hold = '0;
        d1 = '0; d2 = '0; cyc = 0;
        for (int k = 0; k < NK; k++) begin
            m_run[k]  = 0;
            m_rise[k] = 0;
        end
    endtask

    task automatic model_step(input logic [NK-1:0] raw);
        logic [NK-1:0] seen;
        seen = d2;
        d2   = d1;
        d1   = raw;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            m_press[k]   = 1'b0;
            m_release[k] = 1'b0;
            if (seen[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == D + 1) begin
                    m_level[k] = ~m_level[k];
                    m_run[k]   = 0;
                    if (m_level[k]) begin
                        m_press[k] = 1'b1;
                        m_rise[k]  = cyc;
                    end else begin
                        m_release[k] = 1'b1;
                    end
                end
            end else begin
                m_run[k] = 0;
            end
            m_hold[k] = m_level[k] && (cyc - m_rise[k] >= H);
        end
    endtask

    task automatic tick(input logic [NK-1:0] raw);
        kif.key_raw = raw;
        @(posedge clk);
        model_step(raw);
        #1;
    endtask

    task automatic do_reset();
        kif.key_raw = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        kif.key_raw = NK'($urandom);
        #3 rst_n = 1'b0;
        #2;
        n_checks++; if (kif.key_level !== '0) $display("FAIL reset_level got=%h exp=000", kif.key_level); else n_pass++;
        n_checks++; if (kif.key_press !== '0) $display("FAIL reset_press got=%h exp=000", kif.key_press); else n_pass++;
        n_checks++; if (kif.key_release !== '0) $display("FAIL reset_release got=%h exp=000", kif.key_release); else n_pass++;
        n_checks++; if (kif.key_hold !== '0) $display("FAIL reset_hold got=%h exp=000", kif.key_hold); else n_pass++;
        n_checks++; if (kif.any_pressed !== 1'b0) $display("FAIL reset_any got=%b exp=0", kif.any_pressed); else n_pass++;
        do_reset();
    endtask

    task automatic test_clean_press_release();
        do_reset();
        for (int e = 0; e < 20; e++) begin
            tick(12'h200);
            n_checks++; if (kif.key_level !== (e >= 6 ? 12'h200 : 12'h000)) $display("FAIL press_level e=%0d got=%h", e, kif.key_level); else n_pass++;
            n_checks++; if (kif.key_press !== (e == 6 ? 12'h200 : 12'h000)) $display("FAIL press_pulse e=%0d got=%h", e, kif.key_press); else n_pass++;
            n_checks++; if (kif.key_hold !== (e >= 16 ? 12'h200 : 12'h000)) $display("FAIL press_hold e=%0d got=%h", e, kif.key_hold); else n_pass++;
            n_checks++; if (kif.any_pressed !== (e >= 6)) $display("FAIL press_any e=%0d got=%b", e, kif.any_pressed); else n_pass++;
        end
        // Short release bounce must not disturb level or hold.
        for (int e = 0; e < 6; e++) begin
            tick(e < 2 ? 12'h000 : 12'h200);
            n_checks++; if (kif.key_hold !== 12'h200) $display("FAIL bounce_hold e=%0d got=%h exp=200", e, kif.key_hold); else n_pass++;
            n_checks++; if (kif.key_level !== 12'h200) $display("FAIL bounce_level e=%0d got=%h exp=200", e, kif.key_level); else n_pass++;
        end
        for (int e = 0; e < 10; e++) begin
            tick(12'h000);
            n_checks++; if (kif.key_level !== (e < 6 ? 12'h200 : 12'h000)) $display("FAIL rel_level e=%0d got=%h", e, kif.key_level); else n_pass++;
            n_checks++; if (kif.key_release !== (e == 6 ? 12'h200 : 12'h000)) $display("FAIL rel_pulse e=%0d got=%h", e, kif.key_release); else n_pass++;
            n_checks++; if (kif.key_hold !== (e < 6 ? 12'h200 : 12'h000)) $display("FAIL rel_hold e=%0d got=%h", e, kif.key_hold); else n_pass++;
        end
    endtask

    task automatic test_bounce_reject();
        logic [NK-1:0] pat[7] = '{12'h001, 12'h001, 12'h001, 12'h000, 12'h001, 12'h001, 12'h001};
        do_reset();
        for (int e = 0; e < 15; e++) begin
            tick(e < 7 ? pat[e] : 12'h000);
            n_checks++;
            if ({kif.key_level, kif.key_press, kif.key_release, kif.key_hold, kif.any_pressed} !== '0)
                $display("FAIL bounce_quiet e=%0d level=%h press=%h rel=%h hold=%h any=%b exp all zero",
                         e, kif.key_level, kif.key_press, kif.key_release, kif.key_hold, kif.any_pressed);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int e = 0; e < 10; e++) begin
            tick(12'hFFF);
            n_checks++; if (kif.key_press !== (e == 6 ? 12'hFFF : 12'h000)) $display("FAIL all_press e=%0d got=%h", e, kif.key_press); else n_pass++;
            n_checks++; if (kif.any_pressed !== (e >= 6)) $display("FAIL all_any e=%0d got=%b", e, kif.any_pressed); else n_pass++;
        end
        for (int e = 0; e < 8; e++) begin
            tick(12'h000);
            n_checks++; if (kif.key_release !== (e == 6 ? 12'hFFF : 12'h000)) $display("FAIL all_release e=%0d got=%h", e, kif.key_release); else n_pass++;
            n_checks++; if (kif.key_level !== (e < 6 ? 12'hFFF : 12'h000)) $display("FAIL all_level e=%0d got=%h", e, kif.key_level); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e < 8; e++) tick(12'h020);
        for (int e = 0; e < 4; e++) tick(12'h024);
        rst_n = 1'b0;
        #2;
        n_checks++; if (kif.key_level !== '0) $display("FAIL mid_reset_level got=%h exp=000", kif.key_level); else n_pass++;
        n_checks++; if (kif.any_pressed !== 1'b0) $display("FAIL mid_reset_any got=%b exp=0", kif.any_pressed); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int e = 0; e < 10; e++) begin
            tick(12'h024);
            n_checks++; if (kif.key_press !== (e == 6 ? 12'h024 : 12'h000)) $display("FAIL mid_press e=%0d got=%h", e, kif.key_press); else n_pass++;
            n_checks++; if (kif.key_level !== (e >= 6 ? 12'h024 : 12'h000)) $display("FAIL mid_level e=%0d got=%h", e, kif.key_level); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] raw;
        int            sh;
        do_reset();
        raw = '0;
        for (int seg = 0; seg < 6; seg++) begin
            sh = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 3 : 5);
            for (int c = 0; c < 500; c++) begin
                for (int k = 0; k < NK; k++)
                    if ($urandom_range((1 << sh) - 1) == 0) raw[k] = ~raw[k];
                tick(raw);
                n_checks++; if (kif.key_level !== m_level) $display("FAIL rand_level cyc=%0d got=%h exp=%h", cyc, kif.key_level, m_level); else n_pass++;
                n_checks++; if (kif.key_press !== m_press) $display("FAIL rand_press cyc=%0d got=%h exp=%h", cyc, kif.key_press, m_press); else n_pass++;
                n_checks++; if (kif.key_release !== m_release) $display("FAIL rand_release cyc=%0d got=%h exp=%h", cyc, kif.key_release, m_release); else n_pass++;
                n_checks++; if (kif.key_hold !== m_hold) $display("FAIL rand_hold cyc=%0d got=%h exp=%h", cyc, kif.key_hold, m_hold); else n_pass++;
                n_checks++; if (kif.any_pressed !== (|m_level)) $display("FAIL rand_any cyc=%0d got=%b exp=%b", cyc, kif.any_pressed, |m_level); else n_pass++;
            end
        end
    endtask

    initial begin
        kif.key_raw = '0;
        model_reset();
        test_reset();
        test_clean_press_release();
        test_bounce_reject();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
